// File: rtl/npu_spi_pkg.sv
// Shared types and protocol constants for the NPU SPI command sequencer.
// The register address map is kept separately in npu_params.v.
package npu_spi_pkg;

  typedef enum logic [2:0] {
    WAIT_HDR,
    WAIT_ADDR,
    WAIT_DATA,
    BUS_WR,
    BUS_RD,
    RD_SHIFT
  } cmd_state_t;

  // Which half of the read buffer is presented on MISO.
  typedef enum logic [1:0] {
    TX_ZERO,
    TX_LO,
    TX_HI
  } tx_sel_t;

  localparam logic [7:0]  OP_WR    = 8'hFF;
  localparam logic [7:0]  OP_RD    = 8'h00;
  localparam logic [15:0] HDR_WORD = 16'hFFFF;

  // States in which the host owes us more bytes, so the inter-byte timer runs.
  function automatic logic cmd_open(input cmd_state_t s);
    return (s == WAIT_ADDR) || (s == WAIT_DATA) || (s == RD_SHIFT);
  endfunction

endpackage

// File: rtl/npu_spi_word_asm.sv
// Pairs SPI bytes into 16-bit words (low byte first) and watches the
// inter-byte gap, flagging an abort when the host stalls mid-command.
module npu_spi_word_asm #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        npu_clk,
  input  logic        npu_reset,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx_byte,
  input  logic        byte_discard,
  input  logic        cmd_open,
  output logic [15:0] word,
  output logic        word_vld,
  output logic        half,
  output logic        timeout_hit
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [7:0]    low_reg;
  logic          half_reg;
  logic [15:0]   word_reg;
  logic          word_vld_reg;
  logic [CW-1:0] cnt_reg;
  logic          counting;

  assign counting    = half_reg || cmd_open;
  // A byte arriving on the last cycle reloads the timer instead of aborting.
  assign timeout_hit = counting && !spi_rx_valid && (cnt_reg == CNT_LAST);

  always_ff @(posedge npu_clk or posedge npu_reset) begin
    if (npu_reset) begin
      low_reg      <= 8'h00;
      half_reg     <= 1'b0;
      word_reg     <= 16'h0000;
      word_vld_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      word_vld_reg <= 1'b0;
      if (spi_rx_valid) begin
        cnt_reg <= '0;
        if (!byte_discard) begin
          if (half_reg) begin
            word_reg     <= {spi_rx_byte, low_reg};
            word_vld_reg <= 1'b1;
            half_reg     <= 1'b0;
          end else begin
            low_reg  <= spi_rx_byte;
            half_reg <= 1'b1;
          end
        end
      end else if (timeout_hit) begin
        cnt_reg  <= '0;
        half_reg <= 1'b0;
      end else if (counting) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign word     = word_reg;
  assign word_vld = word_vld_reg;
  assign half     = half_reg;

endmodule

// File: rtl/npu_spi_cmd_ctrl.sv
// SPI command sequencer: decodes header/op-addr/data words, issues one
// register-bus access per command and stages read data for MISO.
module npu_spi_cmd_ctrl #(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] HDR_WORD    = npu_spi_pkg::HDR_WORD
) (
  input  logic        npu_clk,
  input  logic        npu_reset,
  input  logic        spi_rx_valid,
  input  logic [7:0]  spi_rx_byte,
  output logic [7:0]  spi_tx_byte,
  output logic        reg_req,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  input  logic [15:0] reg_rdata,
  output logic        cmd_busy,
  output logic        err_pulse
);

  import npu_spi_pkg::*;

  cmd_state_t  state_reg, state_next;
  tx_sel_t     tx_sel_reg, tx_sel_next;
  logic [7:0]  addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic [15:0] rd_buf_reg, rd_buf_next;
  logic        err_reg, err_next;
  logic        overrun_reg, overrun_next;

  logic [15:0] word;
  logic        word_vld;
  logic        half;
  logic        timeout_hit;
  logic        bus_state;

  assign bus_state = (state_reg == BUS_WR) || (state_reg == BUS_RD);

  npu_spi_word_asm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_word_asm (
    .npu_clk      (npu_clk),
    .npu_reset    (npu_reset),
    .spi_rx_valid (spi_rx_valid),
    .spi_rx_byte  (spi_rx_byte),
    .byte_discard (bus_state),
    .cmd_open     (cmd_open(state_reg)),
    .word         (word),
    .word_vld     (word_vld),
    .half         (half),
    .timeout_hit  (timeout_hit)
  );

  always_ff @(posedge npu_clk or posedge npu_reset) begin
    if (npu_reset) begin
      state_reg   <= WAIT_HDR;
      tx_sel_reg  <= TX_ZERO;
      addr_reg    <= 8'h00;
      wdata_reg   <= 16'h0000;
      rd_buf_reg  <= 16'h0000;
      err_reg     <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tx_sel_reg  <= tx_sel_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rd_buf_reg  <= rd_buf_next;
      err_reg     <= err_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tx_sel_next  = tx_sel_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rd_buf_next  = rd_buf_reg;
    err_next     = 1'b0;
    overrun_next = overrun_reg;

    if (timeout_hit) begin
      state_next  = WAIT_HDR;
      tx_sel_next = TX_ZERO;
      err_next    = 1'b1;
    end else begin
      case (state_reg)
        WAIT_HDR: begin
          if (word_vld && (word == HDR_WORD)) state_next = WAIT_ADDR;
        end
        WAIT_ADDR: begin
          if (word_vld) begin
            addr_next = word[7:0];
            if (word[15:8] == OP_WR) begin
              state_next = WAIT_DATA;
            end else if (word[15:8] == OP_RD) begin
              state_next   = BUS_RD;
              overrun_next = 1'b0;
            end else begin
              state_next = WAIT_HDR;
              err_next   = 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (word_vld) begin
            wdata_next   = word;
            state_next   = BUS_WR;
            overrun_next = 1'b0;
          end
        end
        BUS_WR: begin
          if (spi_rx_valid) begin
            err_next     = 1'b1;
            overrun_next = 1'b1;
          end
          if (reg_ack) state_next = WAIT_HDR;
        end
        BUS_RD: begin
          if (spi_rx_valid) begin
            err_next     = 1'b1;
            overrun_next = 1'b1;
          end
          if (reg_ack) begin
            rd_buf_next = reg_rdata;
            // After an overrun the host is out of frame, so nothing is shifted.
            if (overrun_reg || spi_rx_valid) begin
              state_next = WAIT_HDR;
            end else begin
              tx_sel_next = TX_LO;
              state_next  = RD_SHIFT;
            end
          end
        end
        RD_SHIFT: begin
          if (spi_rx_valid && !half) tx_sel_next = TX_HI;
          if (word_vld) begin
            tx_sel_next = TX_ZERO;
            state_next  = WAIT_HDR;
          end
        end
        default: state_next = WAIT_HDR;
      endcase
    end
  end

  always_comb begin
    case (tx_sel_reg)
      TX_LO:   spi_tx_byte = rd_buf_reg[7:0];
      TX_HI:   spi_tx_byte = rd_buf_reg[15:8];
      default: spi_tx_byte = 8'h00;
    endcase
  end

  assign reg_req   = bus_state;
  assign reg_we    = (state_reg == BUS_WR);
  assign reg_addr  = addr_reg;
  assign reg_wdata = wdata_reg;
  assign cmd_busy  = (state_reg != WAIT_HDR);
  assign err_pulse = err_reg;

endmodule

// File: tb/tb_npu_spi_cmd_ctrl.sv
// Bench for npu_spi_cmd_ctrl: table of commands with a bus-request
// scoreboard, plus hand sequences for timeout, overrun and reset.
module tb_npu_spi_cmd_ctrl;

  logic        npu_clk = 1'b0;
  logic        npu_reset;
  logic        spi_rx_valid;
  logic [7:0]  spi_rx_byte;
  logic [7:0]  spi_tx_byte;
  logic        reg_req;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_ack;
  logic [15:0] reg_rdata;
  logic        cmd_busy;
  logic        err_pulse;

  npu_spi_cmd_ctrl dut (
    .npu_clk      (npu_clk),
    .npu_reset    (npu_reset),
    .spi_rx_valid (spi_rx_valid),
    .spi_rx_byte  (spi_rx_byte),
    .spi_tx_byte  (spi_tx_byte),
    .reg_req      (reg_req),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_ack      (reg_ack),
    .reg_rdata    (reg_rdata),
    .cmd_busy     (cmd_busy),
    .err_pulse    (err_pulse)
  );

  always #5 npu_clk = ~npu_clk;

  typedef struct {
    int          nb;
    logic [63:0] b;       // byte i of the command is b[8*i +: 8]
    bit          exp_req;
    bit          exp_we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_dly;
    int          exp_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[9];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int err_seen = 0;
  int req_seen = 0;
  int req_rise_cyc = 0;
  int last_cyc = 0;
  logic prev_req = 1'b0;

  // Register-bus slave model: ack after ack_delay cycles of reg_req.
  int          ack_delay = 0;
  logic [15:0] rd_value = 16'h0000;
  int          req_cycles = 0;
  bit          ack_sent = 1'b0;

  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 16'h0000;
    forever begin
      @(negedge npu_clk);
      reg_ack = 1'b0;
      if (reg_req && !ack_sent) begin
        if (req_cycles >= ack_delay) begin
          reg_ack   = 1'b1;
          reg_rdata = rd_value;
          ack_sent  = 1'b1;
        end
        req_cycles++;
      end else if (!reg_req) begin
        req_cycles = 0;
        ack_sent   = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and run the output monitors.
  task automatic tick();
    exp_t e;
    @(negedge npu_clk);
    cyc++;
    if (reg_req && !prev_req) begin
      req_seen++;
      req_rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'(reg_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("req_we", 32'(reg_we), 32'(e.we));
        check("req_addr", 32'(reg_addr), 32'(e.addr));
        if (e.we) check("req_wdata", 32'(reg_wdata), 32'(e.wdata));
        $display("bus req: we=%0d addr=%02h wdata=%04h at cycle %0d", reg_we, reg_addr, reg_wdata, cyc);
      end
    end
    prev_req = reg_req;
    if (err_pulse) err_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_rx_valid = 1'b1;
    spi_rx_byte  = b;
    tick();
    spi_rx_valid = 1'b0;
  endtask

  function automatic vec_t mk(input int nb, input logic [63:0] b, input bit rq, input bit we,
                              input logic [7:0] a, input logic [15:0] wd, input logic [15:0] rd,
                              input int dly, input int er);
    vec_t v;
    v.nb = nb; v.b = b; v.exp_req = rq; v.exp_we = we; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.ack_dly = dly; v.exp_err = er;
    return v;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    int err0, req0, n;
    exp_t e;
    err0 = err_seen;
    req0 = req_seen;
    ack_delay = v.ack_dly;
    rd_value  = v.rdata;
    if (v.exp_req) begin
      e.we = v.exp_we; e.addr = v.addr; e.wdata = v.wdata;
      exp_q.push_back(e);
    end
    for (int i = 0; i < v.nb; i++) begin
      last_cyc = cyc;
      send_byte(v.b[8*i +: 8]);
      tick();
    end
    if (v.exp_req) begin
      n = 0;
      while (req_seen == req0 && n < 50) begin tick(); n++; end
      check("req_issued", 32'(req_seen - req0), 32'd1);
      check("req_latency", 32'(req_rise_cyc - last_cyc), 32'd2);
      n = 0;
      while (reg_req && n < 200) begin tick(); n++; end
      check("req_release", 32'(reg_req), 32'd0);
      if (!v.exp_we) begin
        check("tx_lo", 32'(spi_tx_byte), 32'(v.rdata[7:0]));
        send_byte(8'h00);
        check("tx_hi", 32'(spi_tx_byte), 32'(v.rdata[15:8]));
        tick();
        send_byte(8'h00);
        tick();
        check("tx_end", 32'(spi_tx_byte), 32'd0);
      end
    end
    repeat (3) tick();
    check("vec_err_count", 32'(err_seen - err0), 32'(v.exp_err));
    check("vec_req_count", 32'(req_seen - req0), 32'(v.exp_req));
    check("vec_idle", 32'(cmd_busy), 32'd0);
    $display("vec %0d: bytes=%0d req=%0d err=%0d tx=%02h", idx, v.nb, req_seen - req0, err_seen - err0, spi_tx_byte);
  endtask

  initial begin
    int n, err0;
    exp_t e;

    vt[0] = mk(6, 64'h0000_00FF_FF01_FFFF, 1, 1, 8'h01, 16'h00FF, 16'h0000, 0, 0);
    vt[1] = mk(6, 64'h0000_ABCD_FF34_FFFF, 1, 1, 8'h34, 16'hABCD, 16'h0000, 3, 0);
    vt[2] = mk(4, 64'h0000_0000_0001_FFFF, 1, 0, 8'h01, 16'h0000, 16'h00FF, 0, 0);
    vt[3] = mk(4, 64'h0000_0000_007E_FFFF, 1, 0, 8'h7E, 16'h0000, 16'hA55A, 2, 0);
    vt[4] = mk(4, 64'h0000_0000_5A01_FFFF, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 1);
    vt[5] = mk(8, 64'h2211_FF02_FFFF_3412, 1, 1, 8'h02, 16'h2211, 16'h0000, 0, 0);
    vt[6] = mk(4, 64'h0000_0000_8033_FFFF, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 1);
    vt[7] = mk(6, 64'h0000_FFFF_FFFF_FFFF, 1, 1, 8'hFF, 16'hFFFF, 16'h0000, 1, 0);
    vt[8] = mk(4, 64'h0000_0000_0000_FFFF, 1, 0, 8'h00, 16'h0000, 16'hFFFF, 0, 0);

    npu_reset    = 1'b1;
    spi_rx_valid = 1'b0;
    spi_rx_byte  = 8'h00;
    repeat (3) tick();
    npu_reset = 1'b0;
    tick();
    check("rst_tx", 32'(spi_tx_byte), 32'd0);
    check("rst_req", 32'(reg_req), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_busy", 32'(cmd_busy), 32'd0);
    check("rst_err", 32'(err_pulse), 32'd0);

    for (int i = 0; i < 9; i++) apply_vec(i, vt[i]);

    // Single byte then silence: half-word abort.
    err0 = err_seen;
    send_byte(8'hFF);
    n = 0;
    while (err_seen == err0 && n < 1100) begin tick(); n++; end
    check("timeout_cycles", 32'(n), 32'd1024);
    repeat (20) tick();
    check("timeout_err_once", 32'(err_seen - err0), 32'd1);
    check("timeout_idle", 32'(cmd_busy), 32'd0);
    $display("timeout half-word: err after %0d idle cycles", n);
    apply_vec(9, mk(6, 64'h0000_1234_FF05_FFFF, 1, 1, 8'h05, 16'h1234, 16'h0000, 0, 0));

    // Header then silence: aborts out of WAIT_ADDR.
    err0 = err_seen;
    send_byte(8'hFF); tick(); send_byte(8'hFF); tick(); tick();
    check("hdr_busy", 32'(cmd_busy), 32'd1);
    n = 0;
    while (err_seen == err0 && n < 1100) begin tick(); n++; end
    repeat (5) tick();
    check("timeout_addr_err", 32'(err_seen - err0), 32'd1);
    check("timeout_addr_idle", 32'(cmd_busy), 32'd0);
    $display("timeout in command: err after %0d cycles", n);

    // Overrun during a slow read.
    err0 = err_seen;
    ack_delay = 50;
    rd_value  = 16'hBEEF;
    e.we = 1'b0; e.addr = 8'h09; e.wdata = 16'h0000;
    exp_q.push_back(e);
    send_byte(8'hFF); tick(); send_byte(8'hFF); tick();
    send_byte(8'h09); tick(); send_byte(8'h00);
    n = 0;
    while (!reg_req && n < 20) begin tick(); n++; end
    repeat (5) tick();
    send_byte(8'h77);
    check("overrun_err", 32'(err_seen - err0), 32'd1);
    check("overrun_req_held", 32'(reg_req), 32'd1);
    n = 0;
    while (reg_req && n < 200) begin tick(); n++; end
    tick();
    check("overrun_ack_taken", 32'(reg_req), 32'd0);
    check("overrun_idle", 32'(cmd_busy), 32'd0);
    check("overrun_tx", 32'(spi_tx_byte), 32'd0);
    check("overrun_err_once", 32'(err_seen - err0), 32'd1);
    $display("overrun: err=%0d busy=%0d tx=%02h", err_seen - err0, cmd_busy, spi_tx_byte);

    // Reset while a write is waiting for its ack.
    ack_delay = 100000;
    e.we = 1'b1; e.addr = 8'h0A; e.wdata = 16'h6655;
    exp_q.push_back(e);
    send_byte(8'hFF); tick(); send_byte(8'hFF); tick();
    send_byte(8'h0A); tick(); send_byte(8'hFF); tick();
    send_byte(8'h55); tick(); send_byte(8'h66);
    n = 0;
    while (!reg_req && n < 20) begin tick(); n++; end
    check("pre_reset_req", 32'(reg_req), 32'd1);
    repeat (3) tick();
    #2 npu_reset = 1'b1;
    #1 check("reset_req_async", 32'(reg_req), 32'd0);
    check("reset_we", 32'(reg_we), 32'd0);
    check("reset_addr", 32'(reg_addr), 32'd0);
    check("reset_wdata", 32'(reg_wdata), 32'd0);
    check("reset_busy", 32'(cmd_busy), 32'd0);
    check("reset_tx", 32'(spi_tx_byte), 32'd0);
    check("reset_err", 32'(err_pulse), 32'd0);
    tick();
    npu_reset = 1'b0;
    ack_delay = 0;
    tick();
    $display("reset in BUS_WR: req=%0d busy=%0d", reg_req, cmd_busy);
    apply_vec(10, vt[0]);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_spi_cmd_ctrl.md
# npu_spi_cmd_ctrl

Command sequencer between the NPU SPI slave byte shifter and the internal register bus. It assembles received SPI bytes into 16-bit words and decodes the three-word command protocol: header 0xFFFF, then `{op, addr}`, then data or dummy. It issues one register-bus read or write per command and stages read data for the SPI slave to shift out on MISO. Stalls, bad opcodes and bus overruns are reported on a single error pulse that feeds `npu_err_int`.

## Interface
- `TIMEOUT_CYC`, 1024: idle `npu_clk` cycles allowed between bytes inside a command before it is aborted.
- `HDR_WORD`, 16'hFFFF: command header word.
- `npu_clk`  in  1  core clock; all logic is on the rising edge.
- `npu_reset`  in  1  asynchronous, active-high reset.
- `spi_rx_valid`  in  1  one-cycle pulse; a complete byte is on `spi_rx_byte`.
- `spi_rx_byte`  in  8  received byte. Byte 0 of a word is the low byte.
- `spi_tx_byte`  out  8  byte the slave loads at the start of its next byte frame.
- `reg_req`  out  1  register-bus request, held until `reg_ack`.
- `reg_we`  out  1  1 = write, 0 = read; stable while `reg_req` is high.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  16  write data.
- `reg_ack`  in  1  one-cycle completion strobe.
- `reg_rdata`  in  16  read data, valid with `reg_ack`.
- `cmd_busy`  out  1  high whenever the FSM is not in WAIT_HDR.
- `err_pulse`  out  1  one-cycle error strobe.

## Operation
- **Word assembler**
  - First `spi_rx_valid` latches the low byte and sets `half`.
  - Second `spi_rx_valid` forms `word = {byte, low}`, raises internal `word_vld` for one cycle, and clears `half`.
- **FSM states:** WAIT_HDR, WAIT_ADDR, WAIT_DATA, BUS_WR, BUS_RD, RD_SHIFT.
- **WAIT_HDR**
  - A word equal to `HDR_WORD` moves to WAIT_ADDR.
  - Any other word is silently dropped; no error.
- **WAIT_ADDR**
  - Latch `reg_addr = word[7:0]`.
  - `word[15:8] = 8'hFF`: go to WAIT_DATA.
  - `word[15:8] = 8'h00`: go to BUS_RD.
  - Any other op: `err_pulse`, then WAIT_HDR.
- **WAIT_DATA:** on `word_vld`, latch `reg_wdata` and go to BUS_WR.
- **BUS_WR:** `reg_req = 1`, `reg_we = 1`. On `reg_ack`, go to WAIT_HDR.
- **BUS_RD:** `reg_req = 1`, `reg_we = 0`. On `reg_ack`, capture `reg_rdata` into `rd_buf`, set `spi_tx_byte = rd_buf[7:0]`, and go to RD_SHIFT.
- **RD_SHIFT**
  - First dummy byte received: `spi_tx_byte = rd_buf[15:8]`.
  - Second dummy byte (`word_vld`): `spi_tx_byte = 8'h00`, go to WAIT_HDR.
  - Dummy byte contents are ignored.
- **Overrun:** `spi_rx_valid` while in BUS_WR or BUS_RD raises `err_pulse`.
  - The byte is discarded.
  - The bus request completes normally, and the FSM then returns to WAIT_HDR (an RD is not shifted).
- **Timeout:** a counter reloads on every `spi_rx_valid`. It counts while `half = 1`, or while the FSM is in WAIT_ADDR, WAIT_DATA or RD_SHIFT. On reaching `TIMEOUT_CYC`:
  - `err_pulse` fires;
  - `half` clears;
  - the FSM returns to WAIT_HDR;
  - `spi_tx_byte` returns to 8'h00.
- **Simultaneous events:** if `reg_ack` and `spi_rx_valid` arrive in the same cycle, the ack is processed and the byte counts as an overrun.

## Timing
- **Reset values:**
  - FSM = WAIT_HDR, `half` = 0.
  - `spi_tx_byte`, `reg_addr` = 8'h00; `reg_wdata`, `rd_buf` = 16'h0000.
  - `reg_req`, `reg_we`, `cmd_busy`, `err_pulse` = 0.
- **Reset mid-operation:** `reg_req` drops immediately (asynchronous). Any outstanding bus transaction is abandoned; the bus side must tolerate this.
- **Byte to word:** `word_vld` is registered one cycle after the second `spi_rx_valid`.
- **Word to request:** `reg_req` rises on the edge that consumes `word_vld`. This gives two cycles from the last command byte to `reg_req`.
- **Request release:** `reg_req` falls on the edge after `reg_ack`. Zero-wait acks are allowed: `reg_ack` may be high in the first `reg_req` cycle.
- **Read data staging:** `spi_tx_byte` updates one cycle after `reg_ack`.
  - The register bus must ack before the first dummy frame starts.
  - Otherwise the overrun rule applies.
- **Outputs:** all are registered; there are no combinational paths from inputs to outputs.
- **`err_pulse`:** exactly one cycle per error event.

## Structure
- Shared package `npu_spi_pkg` holds:
  - the state enum `cmd_state_t`;
  - the op codes `OP_WR = 8'hFF` and `OP_RD = 8'h00`;
  - `HDR_WORD`.
- The register address constants stay in `npu_params.v`.
- One natural sub-module: `npu_spi_word_asm` (byte-to-word assembler with `half` flag and timeout counter). The FSM and bus logic live in the top module.

## Test plan
- **Write:** bytes FF FF, 01 FF, FF 00 -> one `reg_req` with `we = 1`, `addr = 0x01`, `wdata = 0x00FF`, two cycles after the last byte; no `err_pulse`.
- **Read:** bytes FF FF, 01 00, with the bus returning 0x00FF on ack; send dummies 00 00 -> `spi_tx_byte` = 0xFF then 0x00, then 0x00 at end; FSM in WAIT_HDR.
- **Bad op:** bytes FF FF, 01 5A -> `err_pulse` once, no `reg_req`; a following valid write still completes.
- **Garbage before header:** bytes 12 34, then a valid write -> no error; only one write is issued.
- **Timeout:** a single byte FF, then 1024 idle cycles -> `err_pulse` once, `half` clears; a subsequent header is decoded correctly.
- **Overrun and reset:**
  - Hold `reg_ack` low for 50 cycles in BUS_RD and inject a byte -> `err_pulse`; the ack is still accepted and the FSM returns to WAIT_HDR.
  - Assert `npu_reset` during BUS_WR -> `reg_req` drops in the same cycle and all outputs return to their reset values.
